hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 16-register, 4-bit-address CPU.
- Sits at the decode stage, directly upstream of the EX-stage forwarding logic.
- Resolves the hazards forwarding cannot cover:
  - load-use bubble;
  - taken-branch flush;
  - multi-cycle data-memory wait, with a timeout fault.
- Drives write-enables and flushes of PC, IF/ID, ID/EX and EX/MEM.

Parameters:
- MEM_TIMEOUT, 255: max cycles spent in MEM_WAIT before fault; legal range 1..65535.
- REG_ZERO, 4'h0: hardwired-zero register address; never causes a hazard.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ifid_rs  in  4  source reg A of instruction in IF/ID.
- ifid_rt  in  4  source reg B of instruction in IF/ID.
- ifid_uses_rt  in  1  IF/ID instruction actually reads rt.
- idex_memread  in  1  ID/EX instruction is a load.
- idex_regrd  in  4  ID/EX destination reg.
- branch_taken  in  1  EX stage resolved a taken branch/jump this cycle.
- dmem_req  in  1  EX/MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID becomes NOP.
- idex_flush  out  1  ID/EX becomes NOP (bubble).
- exmem_hold  out  1  EX/MEM and MEM/WB hold contents.
- mem_fault  out  1  sticky timeout flag.
- stall_cnt  out  32  stall statistics (see Optional Feature).
- flush_cnt  out  32  flush statistics (see Optional Feature).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- State register: RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2.
- Other registers: branch_pend (1 bit); wait_cnt ($clog2(MEM_TIMEOUT+1) bits).
- Outputs are combinational from state, registers and inputs; mem_fault is registered.
- While rst=1:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_hold=0.
  - Next state RUN; branch_pend=0, wait_cnt=0, mem_fault=0, counters=0.
  - Reset mid-MEM_WAIT or in FAULT abandons the access with no residue.
- load_use = idex_memread & (idex_regrd!=REG_ZERO) & ((idex_regrd==ifid_rs) | (ifid_uses_rt & idex_regrd==ifid_rt)).
- mem_block = dmem_req & ~dmem_ready.
- Default outputs: pc_write=1, ifid_write=1, flushes=0, exmem_hold=0.
- RUN, priority high to low:
  1. mem_block: pc_write=0, ifid_write=0, idex_flush=0, exmem_hold=1. Next MEM_WAIT, wait_cnt=0. If branch_taken, set branch_pend.
  2. branch_taken | branch_pend: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. Clear branch_pend. Branch wins over load_use; the flushed instruction needs no bubble.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble; the next cycle the load is in EX/MEM and forwarding takes over.
  4. Otherwise: defaults.
- MEM_WAIT:
  - dmem_ready=0:
    - Full hold, same outputs as RUN rule 1.
    - If branch_taken, set branch_pend.
    - If wait_cnt==MEM_TIMEOUT-1, next FAULT and mem_fault<=1; else wait_cnt+1.
  - dmem_ready=1:
    - Outputs per RUN rules 2-4, treating branch_pend|branch_taken as the branch condition.
    - Next RUN, wait_cnt=0. Pipeline advances in the completing cycle; no extra cycle.
- FAULT:
  - pc_write=0, ifid_write=0, exmem_hold=1, flushes=0, mem_fault=1.
  - Held until rst; inputs ignored.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With macro defined:
  - stall_cnt increments each cycle pc_write=0 in RUN or MEM_WAIT, not in FAULT.
  - flush_cnt increments each cycle ifid_flush=1 outside reset.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst.
- Without macro: both ports tied to 0; no counter flops.

Test Plan:
- Load-use on rs: idex_memread=1, idex_regrd=5, ifid_rs=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1. Next cycle, with idex_memread=0: defaults.
- Hazard suppressed: idex_regrd=0 matches ifid_rs=0 -> no stall. ifid_rt=7 matches but ifid_uses_rt=0 -> no stall.
- Branch beats load-use: branch_taken=1 with load_use true -> ifid_flush=1, idex_flush=1, pc_write=1. With HAZARD_STATS_EN, flush_cnt 0->1.
- Memory wait + branch: dmem_req=1, ready=0 for 3 cycles, branch_taken=1 in the first cycle, ready=1 in cycle 4.
  - Cycles 1-3 full hold, exmem_hold=1.
  - Cycle 4: ifid_flush=1, idex_flush=1.
  - Cycle 5: state RUN, branch_pend=0.
- Timeout, MEM_TIMEOUT=4: dmem_req=1, ready never.
  - Cycle 0 RUN; cycles 1-4 MEM_WAIT.
  - Cycle 5: state FAULT, mem_fault=1.
  - Cycle 6: rst=1 -> cycle 7 state RUN, mem_fault=0.
- Reset mid-wait: rst=1 during MEM_WAIT with branch_pend=1 -> next cycle RUN, branch_pend=0. With dmem_req=0 afterwards: no flush, pc_write=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard/stall controller (optional stats via HAZARD_STATS_EN)
module hazard_ctrl #(
    parameter int         MEM_TIMEOUT = 255,
    parameter logic [3:0] REG_ZERO    = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ifid_rs,
    input  logic [3:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        idex_memread,
    input  logic [3:0]  idex_regrd,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_hold,
    output logic        mem_fault,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t         state;
    logic           branch_pend;
    logic [WCW-1:0] wait_cnt;
    logic           mem_fault_q;

    logic load_use;
    logic mem_block;
    logic branch_any;
    logic hold;
    logic active;

    assign load_use = idex_memread & (idex_regrd != REG_ZERO) &
                      ((idex_regrd == ifid_rs) | (ifid_uses_rt & (idex_regrd == ifid_rt)));
    assign mem_block  = dmem_req & ~dmem_ready;
    assign branch_any = branch_taken | branch_pend;
    assign active     = (state == RUN) | (state == MEM_WAIT);
    // Once in MEM_WAIT only the ready strobe matters; the request is already committed.
    assign hold       = (state == RUN) ? mem_block :
                        (state == MEM_WAIT) ? ~dmem_ready : 1'b0;
    assign mem_fault  = mem_fault_q;

    // Pipeline control outputs: reset, fault, memory hold, branch flush, load-use bubble.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (!active || hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
        end else if (branch_any) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Controller state, deferred-branch flag, wait timer and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            branch_pend <= 1'b0;
            wait_cnt    <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_block) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                        if (branch_taken) branch_pend <= 1'b1;
                    end else if (branch_any) begin
                        branch_pend <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        if (branch_taken) branch_pend <= 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= FAULT;
                            mem_fault_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        if (branch_any) branch_pend <= 1'b0;
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating stall/flush statistics, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (active && !pc_write && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (ifid_flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ifid_rs, ifid_rt, idex_regrd;
    logic        ifid_uses_rt, idex_memread, branch_taken, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, mem_fault;
    logic [31:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_ZERO(4'h0)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_memread(idex_memread), .idex_regrd(idex_regrd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_hold(exmem_hold), .mem_fault(mem_fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = faulted
    int          m_mode  = 0;
    bit          m_pend  = 1'b0;
    int          m_waited = 0;
    bit          m_fault = 1'b0;
    longint      m_stall = 0;
    longint      m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}
    function automatic logic [4:0] model_out();
        bit lu, stuck;
        lu = idex_memread && idex_regrd != 4'd0 &&
             (idex_regrd == ifid_rs || (ifid_uses_rt && idex_regrd == ifid_rt));
        stuck = (m_mode == 1) ? !dmem_ready : (dmem_req && !dmem_ready);
        if (rst)                      return 5'b00110;
        if (m_mode == 2 || stuck)     return 5'b00001;
        if (branch_taken || m_pend)   return 5'b11110;
        if (lu)                       return 5'b00010;
        return 5'b11000;
    endfunction

    always @(posedge clk) begin
        logic [4:0] o;
        o = model_out();
        if (rst) begin
            m_mode = 0; m_pend = 0; m_waited = 0; m_fault = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode != 2) begin
            if (o[4] == 1'b0 && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (o[2] == 1'b1 && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (o[0]) begin
                if (branch_taken) m_pend = 1;
                if (m_mode == 0) begin
                    m_mode = 1; m_waited = 1;
                end else if (m_waited == TO) begin
                    m_mode = 2; m_fault = 1;
                end else begin
                    m_waited++;
                end
            end else begin
                if (branch_taken || m_pend) m_pend = 0;
                m_mode = 0; m_waited = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [4:0] e;
        if (chk_en) begin
            e = model_out();
            chk("pc_write",   32'(pc_write),   32'(e[4]));
            chk("ifid_write", 32'(ifid_write), 32'(e[3]));
            chk("ifid_flush", 32'(ifid_flush), 32'(e[2]));
            chk("idex_flush", 32'(idex_flush), 32'(e[1]));
            chk("exmem_hold", 32'(exmem_hold), 32'(e[0]));
            chk("mem_fault",  32'(mem_fault),  32'(m_fault));
`ifdef HAZARD_STATS_EN
            chk("stall_cnt",  stall_cnt, 32'(m_stall));
            chk("flush_cnt",  flush_cnt, 32'(m_flush));
`else
            chk("stall_cnt",  stall_cnt, 32'd0);
            chk("flush_cnt",  flush_cnt, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_rs = 4'd1; ifid_rt = 4'd2; ifid_uses_rt = 1'b0;
        idex_memread = 1'b0; idex_regrd = 4'd9;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_flushes",  32'({ifid_flush, idex_flush}), 32'd3);
        chk("rst_fault",    32'(mem_fault), 32'd0);
        tick();
        rst = 1'b0;

        // Load-use on rs: one bubble, then defaults
        idex_memread = 1'b1; idex_regrd = 4'd5; ifid_rs = 4'd5;
        @(negedge clk);
        chk("lu_rs_stall", 32'({pc_write, ifid_write, idex_flush}), 32'b001);
        tick();
        idex_memread = 1'b0;
        @(negedge clk);
        chk("lu_rs_after", 32'({pc_write, ifid_write, idex_flush}), 32'b110);
        tick();

        // Zero register and unused rt never stall
        idex_memread = 1'b1; idex_regrd = 4'd0; ifid_rs = 4'd0;
        @(negedge clk);
        chk("lu_zero", 32'(pc_write), 32'd1);
        tick();
        idex_regrd = 4'd7; ifid_rs = 4'd3; ifid_rt = 4'd7; ifid_uses_rt = 1'b0;
        @(negedge clk);
        chk("lu_rt_unused", 32'(pc_write), 32'd1);
        tick();
        ifid_uses_rt = 1'b1;
        @(negedge clk);
        chk("lu_rt_used", 32'(pc_write), 32'd0);
        tick();

        // Branch beats load-use
        idle();
        idex_memread = 1'b1; idex_regrd = 4'd5; ifid_rs = 4'd5; branch_taken = 1'b1;
        @(negedge clk);
        chk("br_lu", 32'({pc_write, ifid_flush, idex_flush}), 32'b111);
        chk("br_flush_before", flush_cnt, 32'd0);
        tick();
        idle();
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        chk("br_flush_after", flush_cnt, 32'd1);
`else
        chk("br_flush_after", flush_cnt, 32'd0);
`endif
        tick();

        // Memory wait with branch taken in the first wait cycle
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("mw_hold", 32'({pc_write, ifid_write, exmem_hold}), 32'b001);
            tick();
            branch_taken = 1'b0;
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("mw_done_flush", 32'({pc_write, ifid_flush, idex_flush}), 32'b111);
        tick();
        idle();
        @(negedge clk);
        chk("mw_state_run", 32'(2'(dut.state)), 32'd0);
        chk("mw_pend_clr",  32'(dut.branch_pend), 32'd0);
        chk("mw_no_flush",  32'(ifid_flush), 32'd0);
        tick();

        // Timeout into FAULT
        dmem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        chk("to_c0_run", 32'(2'(dut.state)), 32'd0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("to_wait", 32'(2'(dut.state)), 32'd1);
            tick();
        end
        branch_taken = 1'b1; idex_memread = 1'b1; idex_regrd = 4'd1;
        @(negedge clk);
        chk("to_fault_state", 32'(2'(dut.state)), 32'd2);
        chk("to_fault_flag",  32'(mem_fault), 32'd1);
        chk("to_fault_outs",  32'({pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}), 32'b00001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        chk("to_rst_run",   32'(2'(dut.state)), 32'd0);
        chk("to_rst_fault", 32'(mem_fault), 32'd0);
        tick();

        // Reset in the middle of a wait with a pending branch
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("rmw_pend_set", 32'(dut.branch_pend), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        chk("rmw_run",  32'(2'(dut.state)), 32'd0);
        chk("rmw_pend", 32'(dut.branch_pend), 32'd0);
        chk("rmw_outs", 32'({pc_write, ifid_flush}), 32'b10);
        tick();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
